// File: rtl/pfu_frame_ctrl_pkg.sv
// Shared definitions for the PFU frame scheduler: FSM encoding and default sizes.
// Optional guard-interval feature: PFU_FRAME_CTRL_GAP_EN.
package pfu_frame_ctrl_pkg;

    localparam int unsigned FRAME_LEN_DEF     = 3264;
    localparam int unsigned DW_DEF            = 12;
    localparam int unsigned ADDR_W_DEF        = 12;
    localparam int unsigned FLUSH_TIMEOUT_DEF = 8192;
`ifdef PFU_FRAME_CTRL_GAP_EN
    localparam int unsigned GAP_LEN_DEF       = 16;
`endif

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_WAIT_BUF = 3'd1,
        ST_BURST    = 3'd2,
        ST_FLUSH    = 3'd3,
        ST_GAP      = 3'd4
    } state_e;

endpackage

// File: rtl/pfu_feed_pipe.sv
// Two-stage alignment from buffer read strobe/data to the PFU input port.
// Stage 1 tracks the buffer's one-cycle read latency; stage 2 registers the data.
module pfu_feed_pipe
    import pfu_frame_ctrl_pkg::*;
#(
    parameter int unsigned DW = DW_DEF
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          rd_en,
    input  logic [DW-1:0] rd_re,
    input  logic [DW-1:0] rd_im,
    output logic          stage1_vld,
    output logic [DW-1:0] di_re,
    output logic [DW-1:0] di_im,
    output logic          di_vld
);

    // Valid pipeline; data held when no new sample arrives.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stage1_vld <= 1'b0;
            di_vld     <= 1'b0;
            di_re      <= '0;
            di_im      <= '0;
        end else begin
            stage1_vld <= rd_en;
            di_vld     <= stage1_vld;
            if (stage1_vld) begin
                di_re <= rd_re;
                di_im <= rd_im;
            end
        end
    end

endmodule

// File: rtl/pfu_frame_ctrl.sv
// Frame scheduler: waits for a full buffered frame, bursts it into the PFU,
// waits for the PFU to drain the same number of samples, then releases the buffer.
// Optional macro PFU_FRAME_CTRL_GAP_EN inserts a GAP_LEN-cycle guard between frames.
module pfu_frame_ctrl
    import pfu_frame_ctrl_pkg::*;
#(
    parameter int unsigned FRAME_LEN     = FRAME_LEN_DEF,
    parameter int unsigned ADDR_W        = ADDR_W_DEF,
    parameter int unsigned DW            = DW_DEF,
    parameter int unsigned FLUSH_TIMEOUT = FLUSH_TIMEOUT_DEF
`ifdef PFU_FRAME_CTRL_GAP_EN
    ,parameter int unsigned GAP_LEN      = GAP_LEN_DEF
`endif
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [7:0]        num_frames,
    output logic              busy,
    input  logic              buf_ready,
    output logic              buf_release,
    output logic              buf_rd_en,
    output logic [ADDR_W-1:0] buf_rd_addr,
    input  logic [DW-1:0]     buf_rd_re,
    input  logic [DW-1:0]     buf_rd_im,
    output logic [DW-1:0]     pfu_di_re,
    output logic [DW-1:0]     pfu_di_im,
    output logic              pfu_di_vld,
    input  logic              pfu_do_vld,
    output logic [7:0]        frame_idx,
    output logic              frame_done,
    output logic              all_done,
    output logic              err
);

    localparam int unsigned CNT_W = ADDR_W + 1;
    localparam int unsigned TO_W  = $clog2(FLUSH_TIMEOUT + 1);

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(FRAME_LEN - 1);
    localparam logic [CNT_W-1:0]  FRAME_CNT = CNT_W'(FRAME_LEN);
    localparam logic [TO_W-1:0]   TO_LAST   = TO_W'(FLUSH_TIMEOUT - 1);

`ifdef PFU_FRAME_CTRL_GAP_EN
    localparam int unsigned GAP_W = $clog2(GAP_LEN + 1);
    localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(GAP_LEN - 1);
`endif

    state_e              state_q, state_d;
    logic [7:0]          num_q, num_d;
    logic [7:0]          frame_idx_d;
    logic                busy_d, err_d;
    logic                buf_release_d, frame_done_d, all_done_d;
    logic                buf_rd_en_d;
    logic [ADDR_W-1:0]   buf_rd_addr_d;
    logic [CNT_W-1:0]    drain_cnt_q, drain_cnt_d;
    logic [TO_W-1:0]     flush_cnt_q, flush_cnt_d;
    logic                stage1_vld;
    logic                flush_ok;
    logic                last_frame;
`ifdef PFU_FRAME_CTRL_GAP_EN
    logic [GAP_W-1:0]    gap_cnt_q, gap_cnt_d;
`endif

    // Read strobe/data alignment into the PFU port.
    pfu_feed_pipe #(
        .DW (DW)
    ) u_feed_pipe (
        .clk        (clk),
        .rst_n      (rst_n),
        .rd_en      (buf_rd_en),
        .rd_re      (buf_rd_re),
        .rd_im      (buf_rd_im),
        .stage1_vld (stage1_vld),
        .di_re      (pfu_di_re),
        .di_im      (pfu_di_im),
        .di_vld     (pfu_di_vld)
    );

    // Frame drained: all output samples seen and nothing left in the feed pipe.
    assign flush_ok   = (drain_cnt_q == FRAME_CNT) && !buf_rd_en && !stage1_vld && !pfu_di_vld;
    assign last_frame = ((frame_idx + 8'd1) == num_q);

    // Next-state and registered-output logic.
    always_comb begin
        state_d       = state_q;
        num_d         = num_q;
        frame_idx_d   = frame_idx;
        busy_d        = busy;
        err_d         = err;
        buf_release_d = 1'b0;
        frame_done_d  = 1'b0;
        all_done_d    = 1'b0;
        buf_rd_en_d   = 1'b0;
        buf_rd_addr_d = '0;
        drain_cnt_d   = drain_cnt_q;
        flush_cnt_d   = flush_cnt_q;
`ifdef PFU_FRAME_CTRL_GAP_EN
        gap_cnt_d     = gap_cnt_q;
`endif

        // PFU output samples counted from the first burst cycle, excess ignored.
        if ((state_q == ST_BURST || state_q == ST_FLUSH) && pfu_do_vld && (drain_cnt_q != FRAME_CNT)) begin
            drain_cnt_d = drain_cnt_q + CNT_W'(1);
        end

        case (state_q)
            ST_IDLE: begin
                if (start && (num_frames != 8'd0)) begin
                    num_d       = num_frames;
                    err_d       = 1'b0;
                    frame_idx_d = 8'd0;
                    busy_d      = 1'b1;
                    state_d     = ST_WAIT_BUF;
                end
            end
            ST_WAIT_BUF: begin
                if (buf_ready) begin
                    buf_rd_en_d   = 1'b1;
                    buf_rd_addr_d = '0;
                    drain_cnt_d   = '0;
                    state_d       = ST_BURST;
                end
            end
            ST_BURST: begin
                flush_cnt_d = '0;
                if (buf_rd_addr == LAST_ADDR) begin
                    state_d = ST_FLUSH;
                end else begin
                    buf_rd_en_d   = 1'b1;
                    buf_rd_addr_d = buf_rd_addr + ADDR_W'(1);
                end
            end
            ST_FLUSH: begin
                if (flush_ok) begin
                    buf_release_d = 1'b1;
                    frame_done_d  = 1'b1;
                    frame_idx_d   = frame_idx + 8'd1;
                    if (last_frame) begin
                        all_done_d = 1'b1;
                        busy_d     = 1'b0;
                        state_d    = ST_IDLE;
                    end else begin
`ifdef PFU_FRAME_CTRL_GAP_EN
                        gap_cnt_d  = '0;
                        state_d    = ST_GAP;
`else
                        state_d    = ST_WAIT_BUF;
`endif
                    end
                end else if (flush_cnt_q == TO_LAST) begin
                    err_d         = 1'b1;
                    buf_release_d = 1'b1;
                    frame_done_d  = 1'b1;
                    all_done_d    = 1'b1;
                    busy_d        = 1'b0;
                    state_d       = ST_IDLE;
                end else begin
                    flush_cnt_d = flush_cnt_q + TO_W'(1);
                end
            end
`ifdef PFU_FRAME_CTRL_GAP_EN
            ST_GAP: begin
                if (gap_cnt_q == GAP_LAST) begin
                    state_d = ST_WAIT_BUF;
                end else begin
                    gap_cnt_d = gap_cnt_q + GAP_W'(1);
                end
            end
`endif
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State, counters and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            num_q       <= 8'd0;
            frame_idx   <= 8'd0;
            busy        <= 1'b0;
            err         <= 1'b0;
            buf_release <= 1'b0;
            frame_done  <= 1'b0;
            all_done    <= 1'b0;
            buf_rd_en   <= 1'b0;
            buf_rd_addr <= '0;
            drain_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            num_q       <= num_d;
            frame_idx   <= frame_idx_d;
            busy        <= busy_d;
            err         <= err_d;
            buf_release <= buf_release_d;
            frame_done  <= frame_done_d;
            all_done    <= all_done_d;
            buf_rd_en   <= buf_rd_en_d;
            buf_rd_addr <= buf_rd_addr_d;
            drain_cnt_q <= drain_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

`ifdef PFU_FRAME_CTRL_GAP_EN
    // Guard-interval counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            gap_cnt_q <= '0;
        end else begin
            gap_cnt_q <= gap_cnt_d;
        end
    end
`endif

endmodule

// File: tb/tb_pfu_frame_ctrl.sv
// Scoreboard bench for pfu_frame_ctrl: buffer model, echoing PFU model,
// expected-sample queue drained by a monitor on the falling clock edge.
module tb_pfu_frame_ctrl;

    localparam int FL         = 3264;
    localparam int TO         = 8192;
    localparam int CLK_PERIOD = 10;
`ifdef PFU_FRAME_CTRL_GAP_EN
    localparam int GAP_EXTRA  = 16;
`else
    localparam int GAP_EXTRA  = 0;
`endif

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [7:0]  num_frames;
    logic        busy;
    logic        buf_ready;
    logic        buf_release;
    logic        buf_rd_en;
    logic [11:0] buf_rd_addr;
    logic [11:0] buf_rd_re;
    logic [11:0] buf_rd_im;
    logic [11:0] pfu_di_re;
    logic [11:0] pfu_di_im;
    logic        pfu_di_vld;
    logic        pfu_do_vld;
    logic [7:0]  frame_idx;
    logic        frame_done;
    logic        all_done;
    logic        err;

    pfu_frame_ctrl dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .num_frames  (num_frames),
        .busy        (busy),
        .buf_ready   (buf_ready),
        .buf_release (buf_release),
        .buf_rd_en   (buf_rd_en),
        .buf_rd_addr (buf_rd_addr),
        .buf_rd_re   (buf_rd_re),
        .buf_rd_im   (buf_rd_im),
        .pfu_di_re   (pfu_di_re),
        .pfu_di_im   (pfu_di_im),
        .pfu_di_vld  (pfu_di_vld),
        .pfu_do_vld  (pfu_do_vld),
        .frame_idx   (frame_idx),
        .frame_done  (frame_done),
        .all_done    (all_done),
        .err         (err)
    );

    always #(CLK_PERIOD/2) clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        string name;
        int    act;
        int    exp;
    } chk_t;

    logic [23:0] exp_q[$];
    chk_t        chk_q[$];
    int nvec   = 0;
    int nfail  = 0;
    int n_rel  = 0;
    int n_fd   = 0;
    int n_ad   = 0;
    int n_rden = 0;
    logic pfu_en;
    logic [9:0] pfu_sr;

    // Buffer sample content depends on address and on how many frames were released.
    function automatic logic [23:0] gen(input int a, input int tag);
        logic [11:0] r;
        logic [11:0] i;
        r = 12'(a * 3 + tag * 37);
        i = 12'((a ^ 'h5A5) + tag * 11);
        return {r, i};
    endfunction

    // Frame buffer with one-cycle read latency.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            buf_rd_re <= '0;
            buf_rd_im <= '0;
        end else if (buf_rd_en) begin
            {buf_rd_re, buf_rd_im} <= gen(int'(buf_rd_addr), n_rel);
        end
    end

    // PFU model: echoes input valid 10 cycles later when enabled.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) pfu_sr <= '0;
        else        pfu_sr <= {pfu_sr[8:0], pfu_di_vld};
    end
    assign pfu_do_vld = pfu_en & pfu_sr[9];

    task automatic compare(input string name, input int act, input int exp);
        nvec++;
        if (act != exp) begin
            nfail++;
            $display("FAIL %s: got %0d, required %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: drains stimulus checks, scores samples and addresses, counts pulses.
    initial begin : monitor
        int          exp_addr;
        logic [23:0] last_di;
        logic [23:0] e;
        chk_t        c;
        exp_addr = 0;
        last_di  = '0;
        forever begin
            @(negedge clk);
            while (chk_q.size() > 0) begin
                c = chk_q.pop_front();
                compare(c.name, c.act, c.exp);
            end
            if (!rst_n) begin
                exp_addr = 0;
                last_di  = '0;
            end else begin
                if (buf_rd_en) begin
                    compare("rd_addr", int'(buf_rd_addr), exp_addr);
                    exp_addr = (exp_addr == FL - 1) ? 0 : exp_addr + 1;
                    n_rden++;
                end
                if (pfu_di_vld) begin
                    if (exp_q.size() == 0) begin
                        compare("unexpected_sample", 1, 0);
                    end else begin
                        e = exp_q.pop_front();
                        compare("sample", int'({pfu_di_re, pfu_di_im}), int'(e));
                    end
                    last_di = {pfu_di_re, pfu_di_im};
                end else begin
                    compare("hold", int'({pfu_di_re, pfu_di_im}), int'(last_di));
                end
                if (buf_release) n_rel++;
                if (frame_done)  n_fd++;
                if (all_done)    n_ad++;
            end
        end
    end

    task automatic expect_eq(input string name, input int act, input int exp);
        chk_t c;
        c.name = name;
        c.act  = act;
        c.exp  = exp;
        chk_q.push_back(c);
    endtask

    function automatic logic probe(input int which);
        case (which)
            0:       return all_done;
            1:       return frame_done;
            2:       return buf_rd_en;
            3:       return pfu_di_vld;
            4:       return err;
            5:       return !buf_rd_en;
            6:       return buf_rd_en && (buf_rd_addr == 12'd1000);
            default: return 1'b0;
        endcase
    endfunction

    task automatic wait_for(input int which, input int budget, input string name, output int at);
        at = -1;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (probe(which)) begin
                at = cyc;
                break;
            end
        end
        if (at < 0) expect_eq({name, "_timeout"}, 0, 1);
    endtask

    task automatic do_start(input logic [7:0] n, output int c);
        @(posedge clk); #1;
        start      = 1'b1;
        num_frames = n;
        c          = cyc;
        @(posedge clk); #1;
        start      = 1'b0;
    endtask

    task automatic push_frame(input int tag);
        for (int a = 0; a < FL; a++) exp_q.push_back(gen(a, tag));
    endtask

    function automatic int outs_set();
        return $countones({busy, buf_release, buf_rd_en, buf_rd_addr, pfu_di_re, pfu_di_im,
                           pfu_di_vld, frame_idx, frame_done, all_done, err});
    endfunction

    initial begin : watchdog
        #(CLK_PERIOD * 90000);
        $display("FAIL watchdog: got no completion, required finish within 90000 cycles");
        $fatal(1, "watchdog expired");
    end

    initial begin : stim
        int c, t, t2, run, bad, s_fd, s_ad, s_rel, s_rden, tag;
        rst_n      = 1'b0;
        start      = 1'b0;
        num_frames = 8'd0;
        buf_ready  = 1'b1;
        pfu_en     = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        expect_eq("reset_outputs", outs_set(), 0);
        @(negedge clk);
        rst_n = 1'b1;

        // 1: single frame, latency and contiguity
        s_rel = n_rel; s_fd = n_fd; s_ad = n_ad;
        push_frame(n_rel);
        do_start(8'd1, c);
        wait_for(2, 20, "t1_rd_en", t);
        expect_eq("t1_rd_en_lat", t - c, 2);
        wait_for(3, 20, "t1_vld", t);
        expect_eq("t1_vld_lat", t - c, 4);
        run = 0;
        while (pfu_di_vld && run < FL + 4) begin
            run++;
            @(negedge clk);
        end
        expect_eq("t1_vld_run", run, FL);
        wait_for(1, 100, "t1_fdone", t);
        expect_eq("t1_fdone_lat", t - c, FL + 15);
        expect_eq("t1_adone", int'(all_done), 1);
        expect_eq("t1_release", int'(buf_release), 1);
        expect_eq("t1_busy_end", int'(busy), 0);
        expect_eq("t1_err", int'(err), 0);
        repeat (5) @(posedge clk);
        #1;
        expect_eq("t1_n_rel", n_rel - s_rel, 1);
        expect_eq("t1_n_fd", n_fd - s_fd, 1);
        expect_eq("t1_n_ad", n_ad - s_ad, 1);

        // 2: three frames, buffer not ready before frame 1
        s_fd = n_fd; s_ad = n_ad;
        tag = n_rel;
        for (int k = 0; k < 3; k++) push_frame(tag + k);
        do_start(8'd3, c);
        wait_for(2, 20, "t2_rd0", t);
        expect_eq("t2_idx0", int'(frame_idx), 0);
        wait_for(5, FL + 10, "t2_burst0_end", t);
        buf_ready = 1'b0;
        wait_for(1, 200, "t2_fd0", t);
        expect_eq("t2_idx_after0", int'(frame_idx), 1);
        bad = 0;
        repeat (50) begin
            @(negedge clk);
            if (buf_rd_en) bad++;
        end
        expect_eq("t2_wait_no_rd", bad, 0);
        buf_ready = 1'b1;
        wait_for(2, 10, "t2_rd1", t);
        expect_eq("t2_idx1", int'(frame_idx), 1);
        wait_for(5, FL + 10, "t2_burst1_end", t);
        wait_for(1, 200, "t2_fd1", t);
        wait_for(2, 40, "t2_rd2", t2);
        expect_eq("t2_gap", t2 - t, 1 + GAP_EXTRA);
        expect_eq("t2_idx2", int'(frame_idx), 2);
        wait_for(0, FL + 200, "t2_adone", t);
        repeat (5) @(posedge clk);
        #1;
        expect_eq("t2_n_fd", n_fd - s_fd, 3);
        expect_eq("t2_n_ad", n_ad - s_ad, 1);
        expect_eq("t2_busy_end", int'(busy), 0);

        // 3: PFU silent -> flush timeout, then err cleared by next start
        pfu_en = 1'b0;
        push_frame(n_rel);
        do_start(8'd1, c);
        wait_for(4, FL + TO + 100, "t3_err", t);
        expect_eq("t3_err_lat", t - c, 2 + FL + TO);
        expect_eq("t3_adone", int'(all_done), 1);
        expect_eq("t3_fdone", int'(frame_done), 1);
        expect_eq("t3_release", int'(buf_release), 1);
        expect_eq("t3_busy", int'(busy), 0);
        repeat (3) @(posedge clk);
        #1;
        pfu_en = 1'b1;
        push_frame(n_rel);
        do_start(8'd1, c);
        expect_eq("t3_err_cleared", int'(err), 0);
        wait_for(0, FL + 200, "t3_adone2", t);
        expect_eq("t3_err_final", int'(err), 0);

        // 4: zero-frame start ignored; start during burst ignored
        do_start(8'd0, c);
        bad = 0;
        repeat (10) begin
            @(negedge clk);
            if (busy || buf_rd_en) bad++;
        end
        expect_eq("t4_zero_ignored", bad, 0);
        s_rden = n_rden; s_ad = n_ad;
        push_frame(n_rel);
        do_start(8'd1, c);
        wait_for(2, 20, "t4_rd", t);
        repeat (500) @(negedge clk);
        start      = 1'b1;
        num_frames = 8'd5;
        @(negedge clk);
        start      = 1'b0;
        expect_eq("t4_busy_mid", int'(busy), 1);
        wait_for(0, FL + 200, "t4_adone", t);
        bad = 0;
        repeat (20) begin
            @(negedge clk);
            if (busy || buf_rd_en) bad++;
        end
        expect_eq("t4_no_restart", bad, 0);
        #1;
        expect_eq("t4_rd_count", n_rden - s_rden, FL);
        expect_eq("t4_n_ad", n_ad - s_ad, 1);

        // 5: reset mid-burst, then a clean frame
        s_rel = n_rel;
        push_frame(n_rel);
        do_start(8'd1, c);
        wait_for(6, FL, "t5_addr1000", t);
        rst_n = 1'b0;
        #1;
        expect_eq("t5_reset_outputs", outs_set(), 0);
        exp_q.delete();
        repeat (3) @(negedge clk);
        expect_eq("t5_no_release", n_rel - s_rel, 0);
        rst_n = 1'b1;
        s_rden = n_rden; s_ad = n_ad; s_rel = n_rel;
        push_frame(n_rel);
        do_start(8'd1, c);
        wait_for(0, FL + 200, "t5_adone", t);
        repeat (2) @(posedge clk);
        #1;
        expect_eq("t5_rd_count", n_rden - s_rden, FL);
        expect_eq("t5_n_ad", n_ad - s_ad, 1);
        expect_eq("t5_n_rel", n_rel - s_rel, 1);

        // 6: two frames back to back, inter-frame spacing
        s_fd = n_fd;
        tag = n_rel;
        push_frame(tag);
        push_frame(tag + 1);
        do_start(8'd2, c);
        wait_for(1, FL + 200, "t6_fd0", t);
        wait_for(2, 40, "t6_rd1", t2);
        expect_eq("t6_gap", t2 - t, 1 + GAP_EXTRA);
        wait_for(0, FL + 200, "t6_adone", t);
        repeat (2) @(posedge clk);
        #1;
        expect_eq("t6_n_fd", n_fd - s_fd, 2);
        expect_eq("sb_drained", exp_q.size(), 0);

        repeat (3) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
        $finish;
    end

endmodule

// File: doc/pfu_frame_ctrl.md
Name: pfu_frame_ctrl

Overview:
Frame scheduler that sequences IFFT+CP output frames from the symbol buffer into the PFU.
- Waits for a full frame in the buffer, then issues a contiguous FRAME_LEN-sample burst with pfu_di_vld.
- Waits for the PFU to drain the same number of output samples, releases the buffer, and repeats for num_frames frames.
- Sits between the IFFT/CP stage's frame buffer and the PFU; the top-level sequencer drives start.

Parameters:
FRAME_LEN, 3264, samples per OFDM frame (IFFT+CP output)
ADDR_W, 12, buffer read address width (2**ADDR_W >= FRAME_LEN)
DW, 12, sample width per I/Q rail
FLUSH_TIMEOUT, 8192, max cycles in FLUSH before error abort
GAP_LEN, 16, idle cycles between bursts (optional feature only)

Ports:
clk  in  1  system clock, all logic on rising edge
rst_n  in  1  asynchronous active-low reset
start  in  1  one-cycle run request
num_frames  in  8  frames per run, sampled on accepted start
busy  out  1  high from accepted start until all_done
buf_ready  in  1  buffer holds a complete frame
buf_release  out  1  one-cycle pulse: frame consumed, buffer may refill
buf_rd_en  out  1  buffer read strobe, 1-cycle read latency
buf_rd_addr  out  ADDR_W  buffer read address
buf_rd_re  in  DW  buffer read data, real
buf_rd_im  in  DW  buffer read data, imaginary
pfu_di_re  out  DW  PFU input, real
pfu_di_im  out  DW  PFU input, imaginary
pfu_di_vld  out  1  PFU input valid
pfu_do_vld  in  1  PFU output valid, counted for drain
frame_idx  out  8  index of frame in progress
frame_done  out  1  one-cycle pulse per completed frame
all_done  out  1  one-cycle pulse at end of run
err  out  1  sticky flush-timeout flag, cleared on accepted start

Behaviour:
- Reset values: every output is 0 and the FSM is in IDLE. Reset is asynchronous.
- Reset asserted mid-run aborts at once: no release, done or all_done pulses; buffer contents are ignored.
- IDLE:
  - start with num_frames != 0 is accepted: latch num_frames, clear err and frame_idx, busy=1, go to WAIT_BUF.
  - start with num_frames == 0 is ignored.
  - start while busy is ignored in every state.
- WAIT_BUF: stay while buf_ready=0. When buf_ready=1, go to BURST on the next edge.
- BURST:
  - buf_rd_en=1 for exactly FRAME_LEN consecutive cycles; buf_rd_addr runs 0..FRAME_LEN-1.
  - Read data is registered once, so pfu_di_vld/re/im trail buf_rd_en by 2 cycles.
  - The burst is contiguous; buf_ready is not re-checked during it.
  - Go to FLUSH when the last address is issued.
- FLUSH:
  - Count pfu_do_vld cycles from the first burst cycle onward.
  - When the count reaches FRAME_LEN, the pending pfu_di_vld pipeline is empty, and that holds in the same cycle, pulse buf_release and frame_done.
  - Then frame_idx++. If frames remain, go to WAIT_BUF; otherwise pulse all_done, busy=0, go to IDLE.
- Output samples beyond FRAME_LEN are ignored.
- Timeout: if FLUSH lasts FLUSH_TIMEOUT cycles, set err=1, pulse buf_release, frame_done and all_done together, and go to IDLE.
- Latency: with buf_ready=1, start at cycle C gives first buf_rd_en at C+2 and first pfu_di_vld at C+4. Last pfu_di_vld is at C+3+FRAME_LEN.
- pfu_di_re/im hold their last value when pfu_di_vld=0. Data passes through unmodified at DW bits.
- Counters: the sample counter is ADDR_W+1 bits wide; the frame counter is 8 bits. num_frames=255 runs 255 frames without wrap.

Optional Feature:
Macro PFU_FRAME_CTRL_GAP_EN.
- Defined: after frame_done, when frames remain, enter GAP for GAP_LEN cycles with pfu_di_vld=0, then go to WAIT_BUF. Gives the PFU filter tails a guard interval.
- Undefined: no GAP state, GAP_LEN is unused, and FLUSH goes directly to WAIT_BUF.

Decomposition:
- Shared package/header holds:
  - FSM state encodings (IDLE, WAIT_BUF, BURST, FLUSH, GAP);
  - the FRAME_LEN default, 3264;
  - the DW default, 12.
- The existing global define header supplies CLK_PERIOD for benches only.
- One natural sub-module: pfu_feed_pipe, the 2-stage buf_rd_en/data to pfu_di_* alignment register.

Test Plan:
1. num_frames=1, buf_ready=1, PFU model echoes vld after 10 cycles, start at C → 3264 contiguous pfu_di_vld from C+4, addresses 0..3263 in order; one each of buf_release, frame_done, all_done; busy low after all_done; err=0.
2. num_frames=3, buf_ready dropped for 50 cycles before frame 2 → controller waits in WAIT_BUF with no rd_en; frame_idx steps 0,1,2; three frame_done pulses, one all_done.
3. PFU model never asserts pfu_do_vld → err=1 exactly FLUSH_TIMEOUT cycles into FLUSH; all_done pulses; busy=0; next start clears err.
4. start with num_frames=0, and start pulsed mid-burst → no busy change, no restart, burst count stays 3264.
5. rst_n low at sample 1000 of burst → all outputs 0 immediately; after release, a fresh start runs a clean frame from address 0.
6. With PFU_FRAME_CTRL_GAP_EN defined, num_frames=2 → exactly 16 idle cycles between frame_done and the next WAIT_BUF; without the macro, none.
